// File: rtl/logic_unit_pkg.sv
// Operation codes shared by the logic unit, its operand producers and the bench.
package logic_unit_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_AND  = 3'b000;
    localparam op_t OP_OR   = 3'b001;
    localparam op_t OP_XOR  = 3'b010;
    localparam op_t OP_NAND = 3'b011;
    localparam op_t OP_NOR  = 3'b100;
    localparam op_t OP_XNOR = 3'b101;
    localparam op_t OP_ANDN = 3'b110;
    localparam op_t OP_PASS = 3'b111;

endpackage

// File: rtl/logic_op_core.sv
// Combinational bitwise operator: decodes the op code and produces a WIDTH-bit result.
module logic_op_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  op_t              i_op,
    output logic [WIDTH-1:0] o_result
);

    always_comb begin
        o_result = '0;
        case (i_op)
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_NAND: o_result = ~(i_a & i_b);
            OP_NOR:  o_result = ~(i_a | i_b);
            OP_XNOR: o_result = ~(i_a ^ i_b);
            OP_ANDN: o_result = i_a & ~i_b;
            OP_PASS: o_result = i_a;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_logic_unit_pipe.sv
// Registered bitwise logic unit with accumulator, valid/ready handshake and
// a single-entry output register carrying zero/all-ones/parity flags.
module bitwise_logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  op_t              op,
    input  logic             acc_mode,
    input  logic             acc_clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic             zero,
    output logic             all_ones,
    output logic             parity
);

    // Flag order: {zero, all_ones, parity}
    function automatic logic [2:0] calc_flags(input logic [WIDTH-1:0] v);
        return {~|v, &v, ^v};
    endfunction

    logic             r_vld_p1;
    logic [WIDTH-1:0] r_res_p1;
    logic [2:0]       r_flags_p1;
    logic [WIDTH-1:0] r_acc;

    logic             w_accept;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_result;
    logic [2:0]       w_flags;

    assign in_ready = !r_vld_p1 || out_ready;
    assign w_accept = in_valid && in_ready;

    // A same-cycle clear takes effect before the accumulator is used as operand B.
    assign w_b_eff = acc_mode ? (acc_clr ? ACC_INIT : r_acc) : b;

    logic_op_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_a      (a),
        .i_b      (w_b_eff),
        .i_op     (op),
        .o_result (w_result)
    );

    assign w_flags = calc_flags(w_result);

    // Stage p1: result, flags and valid are captured together on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1   <= 1'b0;
            r_res_p1   <= '0;
            r_flags_p1 <= 3'b000;
        end else if (w_accept) begin
            r_vld_p1   <= 1'b1;
            r_res_p1   <= w_result;
            r_flags_p1 <= w_flags;
        end else if (out_ready) begin
            r_vld_p1   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= ACC_INIT;
        end else if (w_accept && acc_mode) begin
            r_acc <= w_result;
        end else if (acc_clr) begin
            r_acc <= ACC_INIT;
        end
    end

    assign out_valid = r_vld_p1;
    assign o         = r_res_p1;
    assign zero      = r_flags_p1[2];
    assign all_ones  = r_flags_p1[1];
    assign parity    = r_flags_p1[0];

endmodule

// File: doc/bitwise_logic_unit_pipe.md
Name: bitwise_logic_unit_pipe

Overview:
Parametrised, registered bitwise logic unit that generalises the 8-bit AND datapath. It has a selectable operation set, an accumulate mode and valid/ready flow control. It computes one WIDTH-bit bitwise result per accepted transaction and presents it through a single-entry output register with result flags. It sits between an operand producer and any downstream consumer that may stall.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
ACC_INIT, {WIDTH{1'b1}}, accumulator value after reset or acc_clr (all-ones = AND identity)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand transaction present
in_ready  output  1  unit can accept a transaction this cycle
op  input  3  operation select, sampled on accept
acc_mode  input  1  1 = operand B is the internal accumulator, not b; sampled on accept
acc_clr  input  1  load accumulator with ACC_INIT
a  input  WIDTH  operand A
b  input  WIDTH  operand B (ignored when acc_mode=1)
out_valid  output  1  o and flags hold a valid result
out_ready  input  1  consumer takes result this cycle
o  output  WIDTH  registered result
zero  output  1  o == 0
all_ones  output  1  o == all ones
parity  output  1  XOR-reduction of o

Behaviour:
- Clock/reset: one clock clk; reset rst is synchronous, active-high; all registers update only on rising clk.
- Reset values: out_valid=0, o=0, zero=0, all_ones=0, parity=0, accumulator=ACC_INIT. in_ready=1 after reset.
- Op codes: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 ANDN (A & ~B), 111 PASS (A).
- Accept: transaction accepted when in_valid && in_ready. in_ready = !out_valid || out_ready (combinational, no bubble on continuous streaming).
- Latency: 1 cycle. Result and flags are registered on the accept edge; out_valid=1 the following cycle.
- Hold: while out_valid && !out_ready, o, flags and out_valid hold stable; in_ready=0.
- Drain: out_valid && out_ready with no new accept -> out_valid=0 next cycle. o and flags keep their last value (don't-care to consumer).
- Flags are computed from the new result in the same register stage as o; they are never combinational from o.
- Accumulate: on accept with acc_mode=1, B = accumulator and accumulator <= result. acc_mode=0 never modifies the accumulator.
- acc_clr without accept: accumulator <= ACC_INIT.
- acc_clr with acc_mode accept in the same cycle: clear applies first, so B = ACC_INIT and accumulator <= result.
- acc_clr with acc_mode=0 accept in the same cycle: accumulator <= ACC_INIT; the result is unaffected.
- Inputs are ignored when not accepted; op, a, b and acc_mode need only be stable in the accept cycle.
- Reset mid-operation: a pending result is discarded (out_valid=0) and the accumulator returns to ACC_INIT, regardless of out_ready, in_valid or acc_clr.
- Widths: all operations are strictly bitwise, with no carries. WIDTH=1 is legal; then zero = !o and all_ones = o.

Decomposition:
- Package logic_unit_pkg: 3-bit op-code localparams (OP_AND..OP_PASS) and op typedef, shared with producers and the bench.
- Sub-module logic_op_core (parameter WIDTH): purely combinational a/b/op -> result. Keeps the opcode decode separate from the pipeline/handshake/accumulator control in the top.

Test Plan:
1. WIDTH=8, reset, out_ready=1, accept AND a=8'hF0 b=8'h3C -> next cycle out_valid=1, o=8'h30, zero=0, all_ones=0, parity=0.
2. out_ready=0 after test 1, present XOR a=8'hAA b=8'hAA -> in_ready=0, o holds 8'h30 for 3 cycles. Raise out_ready -> XOR accepted same cycle, next cycle o=8'h00, zero=1, parity=0.
3. Back-to-back stream with out_ready=1, in_valid=1 for 4 cycles (OR, NAND, ANDN, PASS with a=8'h0F b=8'h33) -> in_ready stays 1, o = 8'h3F, 8'hFC, 8'h0C, 8'h0F on consecutive cycles, with no bubbles.
4. Accumulate: acc_clr pulse, then acc_mode=1 AND a=8'hFE, then a=8'h7F -> o=8'hFE then 8'h7E. Next, acc_clr together with acc_mode AND a=8'h81 -> o=8'h81.
5. Reset mid-op: result pending with out_ready=0, assert rst 1 cycle -> out_valid=0 next cycle. Following acc_mode AND a=8'h55 -> o=8'h55, confirming accumulator=ACC_INIT.
6. WIDTH=32: NOR a=0 b=0 -> o=32'hFFFF_FFFF, all_ones=1, parity=0. XNOR a=32'h1 b=0 -> o=32'hFFFF_FFFE, parity=1.
